// File: rtl/collect8_if.sv
// Stream-in / parallel-word-out bundle for the 8-tap collector.
// The master drives samples and downstream ready; the slave is the collector.
interface collect8_if #(
  parameter int WIDTH = 18
);
  logic signed [WIDTH-1:0] din;
  logic                    inValid;
  logic                    sync;
  logic                    inReady;
  logic signed [WIDTH-1:0] A, B, C, D, E, F, G, H;
  logic                    outValid;
  logic                    outReady;
  logic                    overflow;
  logic                    clrOvf;
  logic                    frameErr;

  modport master (
    output din, inValid, sync, outReady, clrOvf,
    input  inReady, A, B, C, D, E, F, G, H, outValid, overflow, frameErr
  );

  modport slave (
    input  din, inValid, sync, outReady, clrOvf,
    output inReady, A, B, C, D, E, F, G, H, outValid, overflow, frameErr
  );
endinterface

// File: rtl/collect8.sv
// Serial-to-parallel tap collector: groups 8 accepted samples into slots A..H
// and holds them as one word until downstream takes it, with optional saturating gain.
module collect8 #(
  parameter int WIDTH = 18,
  parameter int SHIFT = 0
) (
  input logic        clk,
  input logic        reset,
  collect8_if.slave  bus
);
  localparam int EW = WIDTH + SHIFT;
  localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic {FILL, FULL} state_t;

  state_t                  r_state, w_stateNext;
  logic [2:0]              r_count, w_countNext;
  logic signed [WIDTH-1:0] r_slot [8];
  logic                    r_overflow;
  logic                    r_frameErr, w_frameErrNext;
  logic                    w_accept, w_restart;
  logic signed [EW-1:0]    w_ext, w_shifted;
  logic [SHIFT:0]          w_upper;
  logic                    w_satHi, w_satLo, w_sat;
  logic [WIDTH-1:0]        w_sample;

  // Bits above the result's sign bit must all equal it, otherwise the shift overflowed.
  assign w_ext     = EW'($signed(bus.din));
  assign w_shifted = w_ext <<< SHIFT;
  assign w_upper   = w_shifted[EW-1:WIDTH-1];
  assign w_satHi   = ~w_upper[SHIFT] & (|w_upper);
  assign w_satLo   = w_upper[SHIFT] & ~(&w_upper);
  assign w_sat     = w_satHi | w_satLo;
  assign w_sample  = w_satHi ? POS_LIM :
                     w_satLo ? NEG_LIM : w_shifted[WIDTH-1:0];

  assign bus.inReady = ~reset & ((r_state == FILL) | bus.outReady);
  assign w_accept    = bus.inValid & bus.inReady;

  always_comb begin
    w_stateNext    = r_state;
    w_countNext    = r_count;
    w_frameErrNext = 1'b0;
    w_restart      = 1'b0;
    if (w_accept) begin
      if (bus.sync || (r_state == FULL)) begin
        w_restart      = 1'b1;
        w_countNext    = 3'd1;
        w_frameErrNext = bus.sync && (r_state == FILL) && (r_count != 3'd0);
      end else begin
        w_countNext = r_count + 3'd1;
      end
    end
    case (r_state)
      FILL: if (w_accept && !bus.sync && (r_count == 3'd7)) w_stateNext = FULL;
      FULL: if (bus.outReady) w_stateNext = FILL;
      default: w_stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_count    <= 3'd0;
      r_frameErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_frameErr <= w_frameErrNext;
    end
  end

  // A restart (sync, or a sample arriving as the full word leaves) always lands in slot A.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_slot[i] <= '0;
    end else if (w_accept) begin
      if (w_restart) r_slot[0] <= w_sample;
      else           r_slot[r_count] <= w_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   r_overflow <= 1'b0;
    else if (w_accept && w_sat)  r_overflow <= 1'b1;
    else if (bus.clrOvf)         r_overflow <= 1'b0;
  end

  assign bus.A        = r_slot[0];
  assign bus.B        = r_slot[1];
  assign bus.C        = r_slot[2];
  assign bus.D        = r_slot[3];
  assign bus.E        = r_slot[4];
  assign bus.F        = r_slot[5];
  assign bus.G        = r_slot[6];
  assign bus.H        = r_slot[7];
  assign bus.outValid = (r_state == FULL);
  assign bus.overflow = r_overflow;
  assign bus.frameErr = r_frameErr;
endmodule

// File: tb/tb_collect8.sv
// Self-checking bench for collect8: a vector table for the basic fill/frame-error flow
// plus hand sequences for streaming, backpressure, gain saturation and reset.
module tb_collect8;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  collect8_if #(.WIDTH(18)) bus0 ();
  collect8_if #(.WIDTH(18)) bus2 ();

  collect8 #(.WIDTH(18), .SHIFT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  collect8 #(.WIDTH(18), .SHIFT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] din;
    logic        inValid;
    logic        sync;
    logic        outReady;
    logic        expInReady;
    logic        expValid;
    logic        expFrameErr;
    logic        chkSlots;
    logic [17:0] expBase;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mkVec(input logic [17:0] din, input logic inValid, input logic sync,
                                 input logic outReady, input logic expInReady, input logic expValid,
                                 input logic expFrameErr, input logic chkSlots, input logic [17:0] expBase);
    vec_t v;
    v.din = din; v.inValid = inValid; v.sync = sync; v.outReady = outReady;
    v.expInReady = expInReady; v.expValid = expValid; v.expFrameErr = expFrameErr;
    v.chkSlots = chkSlots; v.expBase = expBase;
    return v;
  endfunction

  function automatic logic [143:0] mkWord(input logic [17:0] base);
    logic [143:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[(7-i)*18 +: 18] = base + 18'(i);
    return w;
  endfunction

  function automatic logic [143:0] word0();
    return {bus0.A, bus0.B, bus0.C, bus0.D, bus0.E, bus0.F, bus0.G, bus0.H};
  endfunction

  task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [17:0] din, input logic inValid, input logic sync, input logic outReady);
    bus0.din = din; bus0.inValid = inValid; bus0.sync = sync; bus0.outReady = outReady;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    drive0(v.din, v.inValid, v.sync, v.outReady);
    #1;
    checkBit($sformatf("vec%0d inReady", idx), bus0.inReady, v.expInReady);
    tick();
    checkBit($sformatf("vec%0d outValid", idx), bus0.outValid, v.expValid);
    checkBit($sformatf("vec%0d frameErr", idx), bus0.frameErr, v.expFrameErr);
    if (v.chkSlots) checkOutput($sformatf("vec%0d slots", idx), word0(), mkWord(v.expBase));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [143:0] heldWord;
    logic [143:0] satWord;

    // Test 1 then test 4: fill 1..8, hold, transfer, partial frame cut by sync.
    for (int i = 0; i < 8; i++)
      vecs[i] = mkVec(18'(i + 1), 1'b1, (i == 0), 1'b1, 1'b1, (i == 7), 1'b0, (i == 7), 18'd1);
    vecs[8] = mkVec(18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 18'd1);
    vecs[9] = mkVec(18'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0);
    for (int i = 0; i < 5; i++)
      vecs[10+i] = mkVec(18'h21 + 18'(i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0);
    vecs[15] = mkVec(18'h100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0);
    for (int i = 0; i < 7; i++)
      vecs[16+i] = mkVec(18'h101 + 18'(i), 1'b1, 1'b0, 1'b1, 1'b1, (i == 6), 1'b0, (i == 6), 18'h100);
    vecs[23] = mkVec(18'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0);

    reset = 1'b1;
    drive0(18'h0, 1'b1, 1'b0, 1'b1);
    bus0.clrOvf = 1'b0;
    bus2.din = '0; bus2.inValid = 1'b0; bus2.sync = 1'b0; bus2.outReady = 1'b1; bus2.clrOvf = 1'b0;
    tick();
    tick();
    checkBit("reset inReady", bus0.inReady, 1'b0);
    checkBit("reset outValid", bus0.outValid, 1'b0);
    checkBit("reset overflow", bus0.overflow, 1'b0);
    checkBit("reset frameErr", bus0.frameErr, 1'b0);
    checkOutput("reset slots", word0(), 144'h0);
    reset = 1'b0;
    drive0(18'h0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) applyStimulus(vecs[i], i);

    // Test 2: 24 back-to-back samples with downstream always ready.
    for (int k = 0; k < 24; k++) begin
      drive0(18'h200 + 18'(k), 1'b1, 1'b0, 1'b1);
      #1;
      checkBit($sformatf("stream%0d inReady", k), bus0.inReady, 1'b1);
      tick();
      checkBit($sformatf("stream%0d outValid", k), bus0.outValid, ((k % 8) == 7));
      if ((k % 8) == 7)
        checkOutput($sformatf("stream%0d word", k), word0(), mkWord(18'h200 + 18'(k - 7)));
    end

    // Test 3: backpressure holds the last streamed word, then zero-bubble handoff.
    heldWord = mkWord(18'h210);
    drive0(18'h3333, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      #1;
      checkBit($sformatf("hold%0d inReady", c), bus0.inReady, 1'b0);
      tick();
      checkBit($sformatf("hold%0d outValid", c), bus0.outValid, 1'b1);
      checkOutput($sformatf("hold%0d word", c), word0(), heldWord);
    end
    drive0(18'd9, 1'b1, 1'b0, 1'b1);
    #1;
    checkBit("handoff inReady", bus0.inReady, 1'b1);
    tick();
    checkBit("handoff outValid", bus0.outValid, 1'b0);
    checkBit("handoff frameErr", bus0.frameErr, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive0(18'd10 + 18'(k), 1'b1, 1'b0, 1'b1);
      tick();
      checkBit($sformatf("after%0d outValid", k), bus0.outValid, (k == 6));
    end
    checkOutput("handoff word", word0(), mkWord(18'd9));
    drive0(18'h0, 1'b0, 1'b0, 1'b1);
    tick();
    checkBit("drain outValid", bus0.outValid, 1'b0);

    // Test 5: SHIFT=2 saturation limits and overflow set/clear priority.
    satWord = {18'h1ffff, 18'h20001, 18'h3fc00, 18'h1fffc, 18'h20000, 18'h00004, 18'h3fffc, 18'h20001};
    bus2.inValid = 1'b1;
    bus2.din = 18'h10000; bus2.sync = 1'b1; bus2.clrOvf = 1'b0; tick();
    checkBit("sat0 overflow", bus2.overflow, 1'b1);
    bus2.din = 18'h2ff00; bus2.sync = 1'b0; bus2.clrOvf = 1'b1; tick();
    checkBit("sat1 set wins overflow", bus2.overflow, 1'b1);
    bus2.din = 18'h3ff00; bus2.clrOvf = 1'b1; tick();
    checkBit("sat2 cleared overflow", bus2.overflow, 1'b0);
    bus2.clrOvf = 1'b0;
    bus2.din = 18'h07fff; tick();
    bus2.din = 18'h38000; tick();
    bus2.din = 18'h00001; tick();
    bus2.din = 18'h3ffff; tick();
    checkBit("sat6 overflow", bus2.overflow, 1'b0);
    checkBit("sat6 outValid", bus2.outValid, 1'b0);
    bus2.din = 18'h20000; tick();
    checkBit("sat7 overflow", bus2.overflow, 1'b1);
    checkBit("sat7 outValid", bus2.outValid, 1'b1);
    checkOutput("sat word", {bus2.A, bus2.B, bus2.C, bus2.D, bus2.E, bus2.F, bus2.G, bus2.H}, satWord);
    bus2.inValid = 1'b0;
    tick();
    checkBit("sat drain overflow", bus2.overflow, 1'b1);

    // Test 6: reset mid-frame drops partial data and clears sticky/pulse outputs.
    for (int k = 0; k < 4; k++) begin
      drive0(18'h300 + 18'(k), 1'b1, 1'b0, 1'b1);
      tick();
    end
    reset = 1'b1;
    drive0(18'h3aa, 1'b1, 1'b1, 1'b1);
    #1;
    checkBit("rst inReady0", bus0.inReady, 1'b0);
    checkBit("rst inReady2", bus2.inReady, 1'b0);
    tick();
    checkBit("rst outValid", bus0.outValid, 1'b0);
    checkBit("rst frameErr", bus0.frameErr, 1'b0);
    checkBit("rst overflow2", bus2.overflow, 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive0(18'h400 + 18'(k), 1'b1, 1'b0, 1'b1);
      tick();
      checkBit($sformatf("post%0d outValid", k), bus0.outValid, (k == 7));
      checkBit($sformatf("post%0d frameErr", k), bus0.frameErr, 1'b0);
    end
    checkOutput("post-reset word", word0(), mkWord(18'h400));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
